// File: rtl/reg_bank_fwd.sv
// 32 x DATA_W register bank with two combinational read ports and one write port.
// Each read port feeds a 4:1 EX/DM/WB forwarding mux; operand B also has an immediate select.
module reg_bank_fwd #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] ans_ex,
  input  logic [DATA_W-1:0] ans_dm,
  input  logic [DATA_W-1:0] ans_wb,
  input  logic [DATA_W-1:0] imm,
  input  logic [ADDR_W-1:0] RA,
  input  logic [ADDR_W-1:0] RB,
  input  logic [ADDR_W-1:0] RW_dm,
  input  logic [1:0]        mux_sel_A,
  input  logic [1:0]        mux_sel_B,
  input  logic              imm_sel,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic              wr_en_d;
  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;
  logic [DATA_W-1:0] fwd_b;

  // The write happens every cycle; only address 0 is suppressed.
  assign wr_en_d = (RW_dm != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en_d) begin
      regs_q[RW_dm] <= ans_dm;
    end
  end

  // No write-to-read bypass; same-cycle hazards are covered by the forwarding muxes.
  always_comb begin
    rd_a = (RA == '0) ? '0 : regs_q[RA];
    rd_b = (RB == '0) ? '0 : regs_q[RB];
  end

  always_comb begin
    A = rd_a;
    unique case (mux_sel_A)
      2'b00:   A = rd_a;
      2'b01:   A = ans_ex;
      2'b10:   A = ans_dm;
      default: A = ans_wb;
    endcase
  end

  always_comb begin
    fwd_b = rd_b;
    unique case (mux_sel_B)
      2'b00:   fwd_b = rd_b;
      2'b01:   fwd_b = ans_ex;
      2'b10:   fwd_b = ans_dm;
      default: fwd_b = ans_wb;
    endcase
    B = imm_sel ? imm : fwd_b;
  end

endmodule

// File: tb/tb_reg_bank_fwd.sv
// Directed and randomised checks of reg_bank_fwd against a small register-file model,
// with expected operands queued at stimulus time and popped when the outputs are sampled.
module tb_reg_bank_fwd;

  logic        clk;
  logic        rst;
  logic [15:0] ans_ex, ans_dm, ans_wb, imm;
  logic [4:0]  RA, RB, RW_dm;
  logic [1:0]  mux_sel_A, mux_sel_B;
  logic        imm_sel;
  logic [15:0] A, B;

  int unsigned vectors;
  int unsigned miscompares;

  logic [15:0] mdl [32];
  logic [15:0] qa [$];
  logic [15:0] qb [$];

  reg_bank_fwd #(.DATA_W(16), .ADDR_W(5), .NUM_REGS(32)) dut (
    .clk(clk), .rst(rst),
    .ans_ex(ans_ex), .ans_dm(ans_dm), .ans_wb(ans_wb), .imm(imm),
    .RA(RA), .RB(RB), .RW_dm(RW_dm),
    .mux_sel_A(mux_sel_A), .mux_sel_B(mux_sel_B), .imm_sel(imm_sel),
    .A(A), .B(B)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] fwd(input logic [1:0] sel, input logic [15:0] rd);
    case (sel)
      2'b00:   return rd;
      2'b01:   return ans_ex;
      2'b10:   return ans_dm;
      default: return ans_wb;
    endcase
  endfunction

  function automatic logic [15:0] model_a();
    logic [15:0] rd;
    rd = (RA == 5'd0) ? 16'h0000 : mdl[RA];
    return fwd(mux_sel_A, rd);
  endfunction

  function automatic logic [15:0] model_b();
    logic [15:0] rd;
    rd = (RB == 5'd0) ? 16'h0000 : mdl[RB];
    return imm_sel ? imm : fwd(mux_sel_B, rd);
  endfunction

  // Model update uses the inputs held across the coming edge; sampling resumes 1 time unit later.
  task automatic tick();
    if (rst) begin
      for (int i = 0; i < 32; i++) mdl[i] = 16'h0000;
    end else if (RW_dm != 5'd0) begin
      mdl[RW_dm] = ans_dm;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] ea, input logic [15:0] eb);
    logic [15:0] xa, xb;
    qa.push_back(ea);
    qb.push_back(eb);
    #1;
    xa = qa.pop_front();
    xb = qb.pop_front();
    vectors++;
    assert (A === xa) else begin
      miscompares++;
      $error("FAIL %s.A observed=%h expected=%h", tag, A, xa);
    end
    vectors++;
    assert (B === xb) else begin
      miscompares++;
      $error("FAIL %s.B observed=%h expected=%h", tag, B, xb);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    for (int i = 0; i < 32; i++) mdl[i] = 16'h0000;
    rst = 1'b1; ans_ex = '0; ans_dm = '0; ans_wb = '0; imm = '0;
    RA = '0; RB = '0; RW_dm = '0; mux_sel_A = '0; mux_sel_B = '0; imm_sel = 1'b0;
    tick();
    tick();

    // Arbitrary writes, then reset with a write pending to check reset priority
    rst = 1'b0;
    for (int i = 1; i < 32; i++) begin
      RW_dm = 5'(i);
      ans_dm = 16'($urandom);
      tick();
    end
    RA = 5'd5; RB = 5'd6; RW_dm = 5'd0;
    check("pre_reset", model_a(), model_b());
    rst = 1'b1; RW_dm = 5'd5; ans_dm = 16'hAAAA;
    tick();
    rst = 1'b0; RW_dm = 5'd0; ans_dm = 16'h0000;
    check("reset", 16'h0000, 16'h0000);

    // Immediate path
    imm = 16'hFFFF; imm_sel = 1'b1;
    for (int s = 0; s < 4; s++) begin
      mux_sel_B = 2'(s);
      check($sformatf("imm_sel_b%0d", s), 16'h0000, 16'hFFFF);
    end
    imm_sel = 1'b0; mux_sel_B = 2'b00;
    check("imm_off_r6", 16'h0000, 16'h0000);

    // Forwarding A sweep over a non-zero register
    RW_dm = 5'd5; ans_dm = 16'h5A5A;
    tick();
    RW_dm = 5'd0;
    ans_ex = 16'hC000; ans_dm = 16'hD000; ans_wb = 16'hE000;
    mux_sel_A = 2'b00; check("fwdA_00", 16'h5A5A, 16'h0000);
    mux_sel_A = 2'b01; check("fwdA_01", 16'hC000, 16'h0000);
    mux_sel_A = 2'b10; check("fwdA_10", 16'hD000, 16'h0000);
    mux_sel_A = 2'b11; check("fwdA_11", 16'hE000, 16'h0000);
    mux_sel_A = 2'b00;

    // Write then read, no internal bypass before the edge
    RW_dm = 5'd7; ans_dm = 16'hD000; RB = 5'd7;
    check("wr_before_edge", 16'h5A5A, 16'h0000);
    tick();
    RW_dm = 5'd0;
    check("wr_after_edge", 16'h5A5A, 16'hD000);

    // Register 0 protection
    RW_dm = 5'd0; ans_dm = 16'h1234;
    tick();
    RA = 5'd0;
    check("r0_read", 16'h0000, 16'hD000);
    mux_sel_A = 2'b10;
    check("r0_fwd_dm", 16'h1234, 16'hD000);
    mux_sel_A = 2'b00;

    // Forwarding B versus immediate precedence
    ans_dm = 16'hD000; imm = 16'h3C3C;
    mux_sel_B = 2'b01; imm_sel = 1'b0;
    check("fwdB_ex", 16'h0000, 16'hC000);
    imm_sel = 1'b1;
    for (int s = 0; s < 4; s++) begin
      mux_sel_B = 2'(s);
      check($sformatf("imm_over_b%0d", s), 16'h0000, 16'h3C3C);
    end
    imm_sel = 1'b0; mux_sel_B = 2'b00;

    // Same address on both ports
    RA = 5'd7; RB = 5'd7;
    check("same_addr", 16'hD000, 16'hD000);

    // Randomised traffic against the model
    for (int n = 0; n < 200; n++) begin
      RW_dm = 5'($urandom_range(0, 31));
      ans_dm = 16'($urandom);
      ans_ex = 16'($urandom);
      ans_wb = 16'($urandom);
      imm = 16'($urandom);
      RA = 5'($urandom_range(0, 31));
      RB = 5'($urandom_range(0, 31));
      mux_sel_A = 2'($urandom_range(0, 3));
      mux_sel_B = 2'($urandom_range(0, 3));
      imm_sel = ($urandom_range(0, 3) == 0);
      check($sformatf("rand%0d", n), model_a(), model_b());
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
